// File: rtl/dram_array_ctrl_if.sv
// CPU-side request/response bus of the DRAM array controller.
// The master drives single-beat requests; the slave (controller) answers
// with req_ready and, for reads, a one-cycle rsp_valid strobe.
interface dram_array_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LANES-1:0]  req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dram_array_ctrl.sv
// Controller for a word-wide memory made of multiplexed-address DRAM chips.
// Each accepted request runs a fixed ROW -> COL -> PRE sequence on one bank
// line; a free-running timer requests CAS-before-RAS refresh of all banks,
// which takes priority over new requests. All chip strobes are registered.
// BANKS must be a power of two and at least 2.
module dram_array_ctrl #(
  parameter int DATA_W       = 32,
  parameter int LANE_W       = 8,
  parameter int BANKS        = 4,
  parameter int ROW_W        = 5,
  parameter int COL_W        = 5,
  parameter int T_RCD        = 2,
  parameter int T_CAS        = 2,
  parameter int T_RP         = 2,
  parameter int REF_INTERVAL = 256,
  localparam int LANES  = DATA_W / LANE_W,
  localparam int BANK_W = $clog2(BANKS),
  localparam int MUX_W  = (ROW_W > COL_W) ? ROW_W : COL_W,
  localparam int ADDR_W = BANK_W + ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  dram_array_ctrl_if.slave  bus,
  output logic [MUX_W-1:0]  dram_addr,
  output logic [BANKS-1:0]  dram_ras_n,
  output logic [LANES-1:0]  dram_cas_n,
  output logic              dram_we_n,
  output logic [DATA_W-1:0] dram_dq_out,
  output logic              dram_dq_oe,
  input  logic [DATA_W-1:0] dram_dq_in,
  output logic              ref_busy
);

  // Phase counter must hold the longest phase length minus one.
  localparam int CNT_MAX = ((T_RCD + T_CAS) > T_RP) ? (T_RCD + T_CAS) : T_RP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REF_W   = $clog2(REF_INTERVAL);

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    PRE,
    RCBR,
    RREF
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [REF_W-1:0]   ref_cnt;
  logic               ref_pending;
  logic               lat_we;
  logic [COL_W-1:0]   lat_col;
  logic [DATA_W-1:0]  lat_wdata;
  logic [LANES-1:0]   lat_be;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;

  logic [BANK_W-1:0]  req_bank;
  logic [ROW_W-1:0]   req_row;
  logic [COL_W-1:0]   req_col;

  assign req_bank = bus.req_addr[ADDR_W-1 -: BANK_W];
  assign req_row  = bus.req_addr[COL_W +: ROW_W];
  assign req_col  = bus.req_addr[COL_W-1:0];

  // Ready comes only from registered state, so it never depends on req_valid.
  assign bus.req_ready = (state == IDLE) && !ref_pending;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Access/refresh sequencer with the refresh timer; every chip strobe is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ref_cnt     <= REF_W'(REF_INTERVAL - 1);
      ref_pending <= 1'b0;
      ref_busy    <= 1'b0;
      lat_we      <= 1'b0;
      lat_col     <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
      dram_addr   <= '0;
      dram_ras_n  <= '1;
      dram_cas_n  <= '1;
      dram_we_n   <= 1'b1;
      dram_dq_out <= '0;
      dram_dq_oe  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;

      if (ref_cnt == '0) begin
        ref_cnt <= REF_W'(REF_INTERVAL - 1);
      end else begin
        ref_cnt <= ref_cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          if (ref_pending) begin
            state       <= RCBR;
            ref_pending <= 1'b0;
            ref_busy    <= 1'b1;
            dram_cas_n  <= '0;
          end else if (bus.req_valid) begin
            state      <= ROW;
            cnt        <= CNT_W'(T_RCD - 1);
            lat_we     <= bus.req_we;
            lat_col    <= req_col;
            lat_wdata  <= bus.req_wdata;
            lat_be     <= bus.req_be;
            dram_ras_n <= ~(BANKS'(1) << req_bank);
            dram_addr  <= MUX_W'(req_row);
          end
        end

        ROW: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state     <= COL;
            cnt       <= CNT_W'(T_CAS - 1);
            dram_addr <= MUX_W'(lat_col);
            if (lat_we) begin
              dram_cas_n  <= ~lat_be;
              dram_we_n   <= 1'b0;
              dram_dq_oe  <= 1'b1;
              dram_dq_out <= lat_wdata;
            end else begin
              dram_cas_n <= '0;
            end
          end
        end

        COL: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state      <= PRE;
            cnt        <= CNT_W'(T_RP - 1);
            dram_ras_n <= '1;
            dram_cas_n <= '1;
            dram_we_n  <= 1'b1;
            dram_dq_oe <= 1'b0;
            if (!lat_we) begin
              rsp_rdata_q <= dram_dq_in;
              rsp_valid_q <= 1'b1;
            end
          end
        end

        PRE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (ref_pending) begin
            // A refresh that expired during the access starts with no idle gap.
            state       <= RCBR;
            ref_pending <= 1'b0;
            ref_busy    <= 1'b1;
            dram_cas_n  <= '0;
          end else begin
            state    <= IDLE;
            ref_busy <= 1'b0;
          end
        end

        RCBR: begin
          state      <= RREF;
          cnt        <= CNT_W'(T_RCD + T_CAS - 1);
          dram_ras_n <= '0;
        end

        RREF: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state      <= PRE;
            cnt        <= CNT_W'(T_RP - 1);
            dram_ras_n <= '1;
            dram_cas_n <= '1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Expiry sets the single pending flag last so it is never lost to a clear.
      if (ref_cnt == '0) begin
        ref_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_array_ctrl.sv
// Directed bench for dram_array_ctrl with default parameters.
// Each table row holds the inputs driven for one cycle and the outputs
// expected after the following rising edge.
module tb_dram_array_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 100 MHz style free-running clock.
  always #5 clk = ~clk;

  dram_array_ctrl_if #(.DATA_W(32), .LANES(4), .ADDR_W(12)) bus ();

  logic [4:0]  dram_addr;
  logic [3:0]  dram_ras_n;
  logic [3:0]  dram_cas_n;
  logic        dram_we_n;
  logic [31:0] dram_dq_out;
  logic        dram_dq_oe;
  logic [31:0] dram_dq_in;
  logic        ref_busy;

  dram_array_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dram_addr   (dram_addr),
    .dram_ras_n  (dram_ras_n),
    .dram_cas_n  (dram_cas_n),
    .dram_we_n   (dram_we_n),
    .dram_dq_out (dram_dq_out),
    .dram_dq_oe  (dram_dq_oe),
    .dram_dq_in  (dram_dq_in),
    .ref_busy    (ref_busy)
  );

  typedef struct {
    logic        valid;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] dqin;
    logic        rdy;
    logic        busy;
    logic [3:0]  ras;
    logic [3:0]  cas;
    logic        wen;
    logic        oe;
    logic        chka;
    logic [4:0]  maddr;
    logic        rv;
    logic [31:0] rdata;
    logic [31:0] dqout;
  } vec_t;

  vec_t tab[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Counts rising edges since reset was released.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Hard stop in case the design wedges the sequencing below.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [31:0] valid, we, addr, wdata, be, dqin,
                              rdy, busy, ras, cas, wen, oe, chka, maddr, rv, rdata, dqout);
    vec_t v;
    v.valid = valid[0];
    v.we    = we[0];
    v.addr  = addr[11:0];
    v.wdata = wdata;
    v.be    = be[3:0];
    v.dqin  = dqin;
    v.rdy   = rdy[0];
    v.busy  = busy[0];
    v.ras   = ras[3:0];
    v.cas   = cas[3:0];
    v.wen   = wen[0];
    v.oe    = oe[0];
    v.chka  = chka[0];
    v.maddr = maddr[4:0];
    v.rv    = rv[0];
    v.rdata = rdata;
    v.dqout = dqout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.req_valid = v.valid;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_be    = v.be;
    dram_dq_in    = v.dqin;
    step();
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(v.rdy));
    chk({tag, ".ref_busy"}, 32'(ref_busy), 32'(v.busy));
    chk({tag, ".ras_n"}, 32'(dram_ras_n), 32'(v.ras));
    chk({tag, ".cas_n"}, 32'(dram_cas_n), 32'(v.cas));
    chk({tag, ".we_n"}, 32'(dram_we_n), 32'(v.wen));
    chk({tag, ".dq_oe"}, 32'(dram_dq_oe), 32'(v.oe));
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(v.rv));
    chk({tag, ".rsp_rdata"}, bus.rsp_rdata, v.rdata);
    if (v.chka) chk({tag, ".addr"}, 32'(dram_addr), 32'(v.maddr));
    if (v.oe)   chk({tag, ".dq_out"}, dram_dq_out, v.dqout);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, ".ras_n"}, 32'(dram_ras_n), 32'hF);
    chk({tag, ".cas_n"}, 32'(dram_cas_n), 32'hF);
    chk({tag, ".we_n"}, 32'(dram_we_n), 32'h1);
    chk({tag, ".dq_oe"}, 32'(dram_dq_oe), 32'h0);
    chk({tag, ".addr"}, 32'(dram_addr), 32'h0);
    chk({tag, ".dq_out"}, dram_dq_out, 32'h0);
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, ".rsp_rdata"}, bus.rsp_rdata, 32'h0);
    chk({tag, ".ref_busy"}, 32'(ref_busy), 32'h0);
  endtask

  task automatic runTable(input string name);
    for (int i = 0; i < tab.size(); i++) begin
      applyStimulus(tab[i]);
      checkOutput(tab[i], $sformatf("%s[%0d]", name, i));
    end
  endtask

  initial begin
    int found;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    dram_dq_in    = '0;

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) step();
    checkReset("reset");
    rst = 1'b0;
    step();
    chk("reset.ready_after", 32'(bus.req_ready), 32'h1);

    // Read 0xC21 (bank 3, row 1, col 1) then write 0x003 with be=0101.
    tab.delete();
    //               v we addr    wdata        be  dqin          rdy busy ras  cas  wen oe ca ma   rv rdata         dqout
    tab.push_back(mk(1, 0, 'hC21, 0,           0,  0,            0, 0, 'h7, 'hF, 1, 0, 1, 'h01, 0, 0,            0));
    tab.push_back(mk(0, 0, 'hC21, 0,           0,  0,            0, 0, 'h7, 'hF, 1, 0, 1, 'h01, 0, 0,            0));
    tab.push_back(mk(0, 0, 'hC21, 0,           0,  0,            0, 0, 'h7, 'h0, 1, 0, 1, 'h01, 0, 0,            0));
    tab.push_back(mk(0, 0, 'hC21, 0,           0,  'h12345678,   0, 0, 'h7, 'h0, 1, 0, 1, 'h01, 0, 0,            0));
    tab.push_back(mk(0, 0, 'hC21, 0,           0,  'hDEADBEEF,   0, 0, 'hF, 'hF, 1, 0, 0, 0,    1, 'hDEADBEEF,  0));
    tab.push_back(mk(0, 0, 'hC21, 0,           0,  0,            0, 0, 'hF, 'hF, 1, 0, 0, 0,    0, 'hDEADBEEF,  0));
    tab.push_back(mk(0, 0, 'hC21, 0,           0,  0,            1, 0, 'hF, 'hF, 1, 0, 0, 0,    0, 'hDEADBEEF,  0));
    tab.push_back(mk(1, 1, 'h003, 'h11223344,  'h5, 0,           0, 0, 'hE, 'hF, 1, 0, 1, 'h00, 0, 'hDEADBEEF,  0));
    tab.push_back(mk(0, 0, 'hFFF, 'hFFFFFFFF,  'hF, 0,           0, 0, 'hE, 'hF, 1, 0, 1, 'h00, 0, 'hDEADBEEF,  0));
    tab.push_back(mk(0, 0, 'hFFF, 'hFFFFFFFF,  'hF, 0,           0, 0, 'hE, 'hA, 0, 1, 1, 'h03, 0, 'hDEADBEEF,  'h11223344));
    tab.push_back(mk(0, 0, 'hFFF, 'hFFFFFFFF,  'hF, 0,           0, 0, 'hE, 'hA, 0, 1, 1, 'h03, 0, 'hDEADBEEF,  'h11223344));
    tab.push_back(mk(0, 0, 'hFFF, 0,           0,  0,            0, 0, 'hF, 'hF, 1, 0, 0, 0,    0, 'hDEADBEEF,  0));
    tab.push_back(mk(0, 0, 'hFFF, 0,           0,  0,            0, 0, 'hF, 'hF, 1, 0, 0, 0,    0, 'hDEADBEEF,  0));
    tab.push_back(mk(0, 0, 'hFFF, 0,           0,  0,            1, 0, 'hF, 'hF, 1, 0, 0, 0,    0, 'hDEADBEEF,  0));
    runTable("rdwr");

    // Idle until the first refresh request appears.
    found = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!bus.req_ready) begin
        found = 1;
        break;
      end
    end
    chk("idle_ref.found", 32'(found), 32'h1);
    chk("idle_ref.cycle", 32'(cyc), 32'd256);
    chk("idle_ref.busy_pending", 32'(ref_busy), 32'h0);

    tab.delete();
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'hF, 'h0, 1, 0, 0, 0, 0, 'hDEADBEEF, 0));
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h0, 'h0, 1, 0, 0, 0, 0, 'hDEADBEEF, 0));
    for (int i = 0; i < 2; i++)
      tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'hF, 'hF, 1, 0, 0, 0, 0, 'hDEADBEEF, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 'hF, 'hF, 1, 0, 0, 0, 0, 'hDEADBEEF, 0));
    runTable("idle_ref");

    // Align so the second expiry (edge 512) lands in the read's COL phase.
    for (int i = 0; i < 1000 && cyc < 508; i++) step();
    chk("mid_ref.align", 32'(cyc), 32'd508);

    tab.delete();
    //               v we addr    wd be dqin         rdy busy ras  cas  wen oe ca ma   rv rdata        dqout
    tab.push_back(mk(1, 0, 'h7A5, 0, 0, 0,           0, 0, 'hD, 'hF, 1, 0, 1, 'h1D, 0, 'hDEADBEEF, 0));
    tab.push_back(mk(1, 0, 'h7A5, 0, 0, 0,           0, 0, 'hD, 'hF, 1, 0, 1, 'h1D, 0, 'hDEADBEEF, 0));
    tab.push_back(mk(1, 0, 'h7A5, 0, 0, 0,           0, 0, 'hD, 'h0, 1, 0, 1, 'h05, 0, 'hDEADBEEF, 0));
    tab.push_back(mk(1, 0, 'h7A5, 0, 0, 0,           0, 0, 'hD, 'h0, 1, 0, 1, 'h05, 0, 'hDEADBEEF, 0));
    tab.push_back(mk(1, 0, 'h7A5, 0, 0, 'hCAFEF00D,  0, 0, 'hF, 'hF, 1, 0, 0, 0,    1, 'hCAFEF00D, 0));
    tab.push_back(mk(1, 0, 'h7A5, 0, 0, 0,           0, 0, 'hF, 'hF, 1, 0, 0, 0,    0, 'hCAFEF00D, 0));
    tab.push_back(mk(1, 0, 'h7A5, 0, 0, 0,           0, 1, 'hF, 'h0, 1, 0, 0, 0,    0, 'hCAFEF00D, 0));
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(1, 0, 'h7A5, 0, 0, 0,         0, 1, 'h0, 'h0, 1, 0, 0, 0,    0, 'hCAFEF00D, 0));
    for (int i = 0; i < 2; i++)
      tab.push_back(mk(1, 0, 'h7A5, 0, 0, 0,         0, 1, 'hF, 'hF, 1, 0, 0, 0,    0, 'hCAFEF00D, 0));
    tab.push_back(mk(1, 0, 'h7A5, 0, 0, 0,           1, 0, 'hF, 'hF, 1, 0, 0, 0,    0, 'hCAFEF00D, 0));
    tab.push_back(mk(1, 0, 'h7A5, 0, 0, 0,           0, 0, 'hD, 'hF, 1, 0, 1, 'h1D, 0, 'hCAFEF00D, 0));
    tab.push_back(mk(0, 0, 'h7A5, 0, 0, 0,           0, 0, 'hD, 'hF, 1, 0, 1, 'h1D, 0, 'hCAFEF00D, 0));
    tab.push_back(mk(0, 0, 'h7A5, 0, 0, 0,           0, 0, 'hD, 'h0, 1, 0, 1, 'h05, 0, 'hCAFEF00D, 0));
    tab.push_back(mk(0, 0, 'h7A5, 0, 0, 0,           0, 0, 'hD, 'h0, 1, 0, 1, 'h05, 0, 'hCAFEF00D, 0));
    tab.push_back(mk(0, 0, 'h7A5, 0, 0, 'h5A5A5A5A,  0, 0, 'hF, 'hF, 1, 0, 0, 0,    1, 'h5A5A5A5A, 0));
    tab.push_back(mk(0, 0, 'h7A5, 0, 0, 0,           0, 0, 'hF, 'hF, 1, 0, 0, 0,    0, 'h5A5A5A5A, 0));
    tab.push_back(mk(0, 0, 'h7A5, 0, 0, 0,           1, 0, 'hF, 'hF, 1, 0, 0, 0,    0, 'h5A5A5A5A, 0));
    runTable("mid_ref");

    // Write to 0x7E2 interrupted by reset in its first COL cycle.
    tab.delete();
    tab.push_back(mk(1, 1, 'h7E2, 'hA5A5A5A5, 'h3, 0, 0, 0, 'hD, 'hF, 1, 0, 1, 'h1F, 0, 'h5A5A5A5A, 0));
    tab.push_back(mk(0, 0, 'h7E2, 0,          0,   0, 0, 0, 'hD, 'hF, 1, 0, 1, 'h1F, 0, 'h5A5A5A5A, 0));
    tab.push_back(mk(0, 0, 'h7E2, 0,          0,   0, 0, 0, 'hD, 'hC, 0, 1, 1, 'h02, 0, 'h5A5A5A5A, 'hA5A5A5A5));
    runTable("abort_wr");
    rst = 1'b1;
    step();
    checkReset("abort_rst");
    rst = 1'b0;
    step();
    chk("abort_rst.rsp_after", 32'(bus.rsp_valid), 32'h0);
    chk("abort_rst.ready_after", 32'(bus.req_ready), 32'h1);

    // Read 0x865 (bank 2, row 3, col 5) after the aborted write.
    tab.delete();
    tab.push_back(mk(1, 0, 'h865, 0, 0, 0,          0, 0, 'hB, 'hF, 1, 0, 1, 'h03, 0, 0,          0));
    tab.push_back(mk(0, 0, 'h865, 0, 0, 0,          0, 0, 'hB, 'hF, 1, 0, 1, 'h03, 0, 0,          0));
    tab.push_back(mk(0, 0, 'h865, 0, 0, 0,          0, 0, 'hB, 'h0, 1, 0, 1, 'h05, 0, 0,          0));
    tab.push_back(mk(0, 0, 'h865, 0, 0, 0,          0, 0, 'hB, 'h0, 1, 0, 1, 'h05, 0, 0,          0));
    tab.push_back(mk(0, 0, 'h865, 0, 0, 'h0BADC0DE, 0, 0, 'hF, 'hF, 1, 0, 0, 0,    1, 'h0BADC0DE, 0));
    tab.push_back(mk(0, 0, 'h865, 0, 0, 0,          0, 0, 'hF, 'hF, 1, 0, 0, 0,    0, 'h0BADC0DE, 0));
    tab.push_back(mk(0, 0, 'h865, 0, 0, 0,          1, 0, 'hF, 'hF, 1, 0, 0, 0,    0, 'h0BADC0DE, 0));
    runTable("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_array_ctrl.md
Name: dram_array_ctrl

Overview:
- Parametrised controller for a word-wide memory built from an array of multiplexed-address DRAM chips.
- Chips are arranged in BANKS bank lines; each line is DATA_W/LANE_W byte lanes wide.
- Converts a single-beat valid/ready request into timed RAS/CAS/WE sequences on the chip array, with per-lane byte enables.
- Issues periodic CAS-before-RAS refresh to all banks.
- Sits between the CPU-side bus and the physical chip array.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of LANE_W
LANE_W, 8, chip data width; LANES = DATA_W/LANE_W
BANKS, 4, bank lines; power of two; BANK_W = log2(BANKS)
ROW_W, 5, chip row address bits
COL_W, 5, chip column address bits; MUX_W = max(ROW_W, COL_W); ADDR_W = BANK_W+ROW_W+COL_W
T_RCD, 2, RAS-to-CAS cycles (>=1)
T_CAS, 2, CAS active cycles (>=1)
T_RP, 2, precharge cycles (>=1)
REF_INTERVAL, 256, cycles between refresh requests (>=16)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address: [ADDR_W-1 -: BANK_W] bank, next ROW_W bits row, [COL_W-1:0] column
req_wdata  input  DATA_W  write data
req_be  input  LANES  byte-lane write enables
rsp_valid  output  1  one-cycle read-data strobe
rsp_rdata  output  DATA_W  read data; held until the next read
dram_addr  output  MUX_W  multiplexed row/column address
dram_ras_n  output  BANKS  per-bank RAS, active low
dram_cas_n  output  LANES  per-lane CAS, active low; shared across banks
dram_we_n  output  1  write enable, active low
dram_dq_out  output  DATA_W  write data to the chips
dram_dq_oe  output  1  drive enable for dram_dq_out
dram_dq_in  input  DATA_W  read data from the chips
ref_busy  output  1  high while a refresh sequence runs

Behaviour:
- Reset values: FSM=IDLE; all dram_ras_n and dram_cas_n high; dram_we_n=1; dram_dq_oe=0; dram_addr=0; dram_dq_out=0; rsp_valid=0; rsp_rdata=0; ref_busy=0; ref_pending=0; refresh counter loaded with REF_INTERVAL-1.
- Reset mid-access aborts immediately to the reset values; no rsp_valid is produced.
- req_ready = (state==IDLE) && !ref_pending, derived from registered state only.
- A request is accepted when req_valid && req_ready on a clock edge. req_we, address, wdata and be are latched on that edge.
- Request sequence, with cycle 0 being the accept edge:
  - ROW (cycles 1..T_RCD): dram_ras_n[bank]=0, dram_addr=row (zero-extended).
  - COL (next T_CAS cycles): dram_addr=column; the bank RAS stays low.
    - Read: all dram_cas_n=0, dram_we_n=1, dram_dq_oe=0.
    - Write: dram_cas_n=~be, dram_we_n=0, dram_dq_oe=1, dram_dq_out=wdata.
  - PRE (next T_RP cycles): all RAS and CAS high, dram_we_n=1, dram_dq_oe=0. Then return to IDLE.
- Read capture: rsp_rdata <= dram_dq_in on the last COL cycle. rsp_valid=1 for exactly the first PRE cycle.
- Read latency: rsp_valid at cycle T_RCD+T_CAS+1 (cycle 5 with defaults). req_ready returns at cycle T_RCD+T_CAS+T_RP+1 (cycle 7).
- Writes produce no response. A write with be=0 still runs ROW/COL/PRE, but no CAS is asserted.
- Refresh counter:
  - Decrements every cycle.
  - At 0: sets ref_pending and reloads REF_INTERVAL-1.
  - Expiry while ref_pending is already set does not stack (single pending flag).
- Refresh has priority over requests. In IDLE with ref_pending, enter the refresh states instead of accepting a request:
  - RCBR (1 cycle): all dram_cas_n=0.
  - RREF (T_RCD+T_CAS cycles): all dram_cas_n=0, all dram_ras_n=0, dram_we_n=1.
  - PRE (T_RP cycles), then IDLE.
- ref_busy is high from RCBR through the end of PRE. ref_pending clears on entry to RCBR.
- An expiry during an access is serviced directly after that access's PRE, with no IDLE cycle of req_ready=1.
- Back-to-back requests: earliest next accept is the first IDLE cycle; there is no row-open (page) reuse.
- Only one dram_ras_n bit is low at any time except during RREF. dram_we_n is never low outside COL.

Test Plan:
- Reset: hold rst=1 for 3 cycles -> every output at its reset value; req_ready=1 on the first cycle after rst falls.
- Read 0xC21 (defaults) -> cycles 1-2: ras_n=0111, addr=1; cycles 3-4: addr=1, cas_n=0000, we_n=1; dq_in=0xDEADBEEF sampled at cycle 4 -> rsp_valid at cycle 5 with rdata 0xDEADBEEF; req_ready=1 at cycle 7.
- Write addr 0x003, wdata 0x11223344, be=0101 -> COL: cas_n=1010, we_n=0, dq_oe=1, dq_out=0x11223344; ras_n=1110; no rsp_valid.
- Idle after reset -> ref_pending set at cycle 256; RCBR shows cas_n=0000 with ras_n=1111, then ras_n=0000 for 4 cycles; req_ready=0 for 7 cycles; ref_busy high throughout.
- Request held valid so that the refresh expiry lands in the middle of the read's COL phase -> the read completes with correct data; refresh starts right after PRE; req_ready stays 0 until the refresh PRE ends.
- Assert rst during COL of a write -> next cycle all strobes inactive, dq_oe=0; no rsp; a subsequent read completes normally.
